// File: rtl/gcd_pkg.sv
// Shared types and the round-robin pick helper for the GCD scheduler.
package gcd_pkg;

    localparam int unsigned W_DEF = 8;
    localparam int unsigned N_MAX = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // First set bit of req searching upward from (last+1) mod n, with wrap.
    function automatic logic [2:0] rr_pick(
        input logic [N_MAX-1:0] req,
        input logic [2:0]       last,
        input int unsigned      n
    );
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_MAX; i++) begin
            idx = (32'(last) + i) % n;
            if (!found && (i <= n) && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/gcd_core.sv
// Iterative subtract-and-swap GCD datapath: load operands, then one step per enabled edge.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] ld_a,
    input  logic [W-1:0] ld_b,
    output logic [W-1:0] a,
    output logic         term,
    output logic [W-1:0] res
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
            a_d = ld_a;
            b_d = ld_b;
        end else if (step && !term) begin
            if (a_q > b_q) begin
                a_d = a_q - b_q;
            end else begin
                a_d = b_q;
                b_d = a_q;
            end
        end
    end

    // A zero operand makes the other one the answer; equal operands OR to themselves.
    assign term = (a_q == b_q) || (a_q == '0) || (b_q == '0);
    assign res  = a_q | b_q;
    assign a    = a_q;

endmodule

// File: rtl/gcd_sched.sv
// Round-robin arbiter that shares one gcd_core between N requesters.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = W_DEF
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] ina,
    input  logic [N*W-1:0] inb,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [W-1:0]   out,
    output logic           busy
);

    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   out_q, out_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic           busy_q, busy_d;

    logic [IDW-1:0] win;
    logic           load;
    logic           step;
    logic [W-1:0]   ld_a;
    logic [W-1:0]   ld_b;
    logic [W-1:0]   core_a;
    logic           term;
    logic [W-1:0]   res;

    gcd_core #(.W(W)) u_core (
        .clk  (clk),
        .nrst (nrst),
        .load (load),
        .step (step),
        .ld_a (ld_a),
        .ld_b (ld_b),
        .a    (core_a),
        .term (term),
        .res  (res)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(N - 1);
            id_q    <= '0;
            out_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            out_q   <= out_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        out_d   = out_q;
        gnt_d   = '0;
        done_d  = '0;
        load    = 1'b0;
        step    = 1'b0;
        win     = IDW'(rr_pick(N_MAX'(req), 3'(last_q), N));
        ld_a    = ina[32'(win)*W +: W];
        ld_b    = inb[32'(win)*W +: W];

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    load    = 1'b1;
                    id_d    = win;
                    last_d  = win;
                    gnt_d   = N'(1) << win;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (term) begin
                    // a is the answer unless it is the zero operand.
                    out_d   = (core_a != '0) ? core_a : res;
                    done_d  = N'(1) << id_q;
                    state_d = S_IDLE;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched: latency, results, round-robin order, operand latching, reset.
module tb_gcd_sched;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           nrst;
    logic [N-1:0]   req;
    logic [N*W-1:0] ina;
    logic [N*W-1:0] inb;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   out;
    logic           busy;

    int n_chk  = 0;
    int n_fail = 0;

    gcd_sched #(.N(N), .W(W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .req  (req),
        .ina  (ina),
        .inb  (inb),
        .gnt  (gnt),
        .done (done),
        .out  (out),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        ina[i*W +: W] = W'(a);
        inb[i*W +: W] = W'(b);
    endtask

    // Cycles from the grant edge to the cycle in which done shows; busy cycles seen meanwhile.
    task automatic wait_done(output int cyc, output int nb);
        cyc = 0;
        nb  = busy ? 1 : 0;
        while (cyc < 600) begin
            tick();
            cyc++;
            if (done != '0) break;
            if (busy) nb++;
        end
    endtask

    task automatic run_job(input int i, input int a, input int b, input int exp, input int k);
        int cyc, nb;
        set_ops(i, a, b);
        req = N'(1) << i;
        tick();
        check("gnt", 32'(gnt), 32'(1 << i));
        check("gnt_busy", 32'(busy), 32'd1);
        req = '0;
        wait_done(cyc, nb);
        check("job_len", 32'(cyc), 32'(k));
        check("done", 32'(done), 32'(1 << i));
        check("out", 32'(out), 32'(exp));
        check("busy_cycles", 32'(nb), 32'(k));
        tick();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, nb;
        int rr_exp [4];
        nrst = 1'b0;
        req  = '0;
        ina  = '0;
        inb  = '0;
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        nrst = 1'b1;

        run_job(0, 12, 8, 4, 4);
        run_job(0, 7, 7, 7, 1);
        run_job(0, 0, 9, 9, 1);
        run_job(0, 0, 0, 0, 1);

        // Fresh reset so requester 0 has first priority for the rotation test.
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        set_ops(0, 12, 8);
        set_ops(1, 9, 6);
        set_ops(2, 5, 0);
        set_ops(3, 21, 14);
        rr_exp = '{4, 3, 5, 7};
        req = '1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(1 << k));
            req[k] = 1'b0;
            wait_done(cyc, nb);
            check("rr_done", 32'(done), 32'(1 << k));
            check("rr_out", 32'(out), 32'(rr_exp[k]));
        end

        // last is 3: requester 2 runs, then 3 must beat 0 after wrap.
        set_ops(2, 15, 10);
        set_ops(0, 6, 4);
        set_ops(3, 8, 12);
        req = 4'b0100;
        tick();
        check("wrap_gnt2", 32'(gnt), 32'h4);
        req = 4'b1001;
        wait_done(cyc, nb);
        check("wrap_done2", 32'(done), 32'h4);
        check("wrap_out2", 32'(out), 32'd5);
        tick();
        check("wrap_gnt3", 32'(gnt), 32'h8);
        check("wrap_hold5", 32'(out), 32'd5);
        req[3] = 1'b0;
        wait_done(cyc, nb);
        check("wrap_len3", 32'(cyc), 32'd5);
        check("wrap_done3", 32'(done), 32'h8);
        check("wrap_out3", 32'(out), 32'd4);
        tick();
        check("wrap_gnt0", 32'(gnt), 32'h1);
        check("wrap_hold4", 32'(out), 32'd4);
        req[0] = 1'b0;
        wait_done(cyc, nb);
        check("wrap_done0", 32'(done), 32'h1);
        check("wrap_out0", 32'(out), 32'd2);

        // Operands change right after the grant edge; result must use (18,12).
        set_ops(0, 18, 12);
        req = 4'b0001;
        tick();
        check("latch_gnt", 32'(gnt), 32'h1);
        req = '0;
        set_ops(0, 35, 1);
        wait_done(cyc, nb);
        check("latch_len", 32'(cyc), 32'd4);
        check("latch_out", 32'(out), 32'd6);

        // Reset in the middle of a long job.
        set_ops(0, 200, 3);
        req = 4'b0001;
        tick();
        check("mid_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out", 32'(out), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_gnt", 32'(gnt), 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("arst_nodone", 32'(done), 32'd0);
        end
        nrst = 1'b1;
        tick();
        check("post_rst_done", 32'(done), 32'd0);
        run_job(0, 9, 6, 3, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
